icache_boot_loader: RTL and testbench
=====================================

// Module: icache_boot_loader
// PURPOSE
//   Hardware counterpart of loading the instruction cache from an init file.
//   Receives a program image as a byte stream, packs the bytes into 32-bit words
//   and writes them into the icache at sequential word addresses. Holds the
//   processor in reset until the whole image is written.
//   Sits between the host/UART byte source and the Processor icache write port.
// PARAMETERS
//   ADDR_WIDTH  10  icache word-address width; capacity = 2**ADDR_WIDTH words
//   DATA_WIDTH  32  icache word width; fixed at 32 (4 bytes per word)
// PORTS
//   clk           in   1           system clock, all logic on posedge
//   rst           in   1           synchronous, active-high reset
//   rx_data       in   8           stream byte
//   rx_valid      in   1           rx_data is valid this cycle
//   rx_ready      out  1           loader accepts a byte this cycle
//   icache_we     out  1           icache write strobe, one cycle per word
//   icache_addr   out  ADDR_WIDTH  icache word address
//   icache_wdata  out  DATA_WIDTH  icache write data
//   core_nrst     out  1           active-low reset to the Processor
//   done          out  1           image fully written
//   error         out  1           header word count exceeds capacity
// BEHAVIOUR
//   - One clock domain; reset is synchronous and active-high.
//   - Byte transfer occurs on any posedge with rx_valid && rx_ready.
//   - Reset values: rx_ready=0, icache_we=0, icache_addr=0, icache_wdata=0,
//     core_nrst=0, done=0, error=0, state=HDR_HI, word/byte counters=0.
//   - Image format: 16-bit word count N (MSB byte first), then N words.
//     Each word is sent as 4 bytes, most-significant byte first.
//   - FSM states and transitions:
//     HDR_HI: rx_ready=1; on transfer, latch N[15:8] -> HDR_LO.
//     HDR_LO: rx_ready=1; on transfer, latch N[7:0]; then
//       N==0 -> DONE; N>2**ADDR_WIDTH -> ERR; otherwise -> LOAD.
//     LOAD: rx_ready=1 except in the write cycle. Shift each byte into the word
//       register; byte counter wraps 3->0.
//       The cycle after the 4th byte: icache_we=1, icache_addr=word index,
//       icache_wdata=assembled word, rx_ready=0 in that cycle.
//       Word index increments after each write. After write N-1 -> DONE.
//     DONE: rx_ready=0, done=1, core_nrst=1; sticky until rst.
//     ERR: rx_ready=0, error=1, core_nrst=0; sticky until rst. No icache writes.
//   - Write latency: icache_we asserts exactly 1 cycle after the accepting edge
//     of a word's 4th byte. done/core_nrst rise 1 cycle after the last icache_we.
//   - Gaps in rx_valid are allowed anywhere; state and counters hold.
//   - icache_addr and icache_wdata hold their last values when icache_we=0.
//   - Bytes presented in DONE/ERR are not accepted (rx_ready=0).
//   - Reset at any point: return to reset values; discard any partial word and
//     remaining count; already-written icache words are not erased.
//   - N==2**ADDR_WIDTH is legal; the last write goes to address 2**ADDR_WIDTH-1
//     and the word index does not wrap before DONE.
// TESTING
//   1. Stream 00 03, then 11 22 33 44, AA BB CC DD, 01 02 03 04 -> writes
//      0x11223344@0, 0xAABBCCDD@1, 0x01020304@2; done=1 and core_nrst=1
//      one cycle after the 3rd write.
//   2. Header 00 00 -> no icache_we; done=1 the cycle after the 2nd byte.
//   3. ADDR_WIDTH=10, header 04 01 -> error=1, rx_ready=0, core_nrst stays 0,
//      no icache_we.
//   4. Test 1 with random rx_valid gaps of 0-5 cycles -> identical writes,
//      in order; icache_we never asserts twice for one word.
//   5. rst asserted after 6 bytes of Test 1 -> outputs at reset values; then a
//      fresh stream 00 01 DE AD BE EF -> 0xDEADBEEF@0, done=1.
//   6. In DONE, hold rx_valid=1 for 10 cycles -> rx_ready=0, no icache_we, done=1.

Source files
------------

// File: rtl/icache_boot_loader.sv
// Boot loader: receives a program image as a byte stream, packs it into
// 32-bit words and writes them to the icache at sequential word addresses.
// The processor is held in reset (core_nrst=0) until the image is written.
// Image format: 16-bit word count N (MSB first), then N words, MSB first.
module icache_boot_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  icache_we,
  output logic [ADDR_WIDTH-1:0] icache_addr,
  output logic [DATA_WIDTH-1:0] icache_wdata,
  output logic                  core_nrst,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    HDR_HI,
    HDR_LO,
    LOAD,
    WRITE,
    DONE,
    ERR
  } state_t;

  localparam logic [31:0] CAPACITY = 32'd1 << ADDR_WIDTH;

  state_t                  state_q, state_d;
  logic [15:0]             count_q, count_d;
  logic [ADDR_WIDTH-1:0]   word_idx_q, word_idx_d;
  logic [1:0]              byte_cnt_q, byte_cnt_d;
  logic [DATA_WIDTH-1:0]   word_q, word_d;
  logic                    rx_ready_q, rx_ready_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    nrst_q, nrst_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;

  logic                    xfer;
  logic [15:0]             hdr_n;
  logic                    last_word;

  assign xfer      = rx_valid && rx_ready_q;
  assign hdr_n     = {count_q[15:8], rx_data};
  assign last_word = ({{(32-ADDR_WIDTH){1'b0}}, word_idx_q} + 32'd1) == {16'd0, count_q};

  // Next-state and next-output logic; every output is registered so the
  // write strobe lands exactly one cycle after the 4th byte of a word.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    word_idx_d = word_idx_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    rx_ready_d = rx_ready_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    nrst_d     = nrst_q;
    done_d     = done_q;
    error_d    = error_q;
    case (state_q)
      HDR_HI: begin
        rx_ready_d = 1'b1;
        if (xfer) begin
          count_d[15:8] = rx_data;
          state_d       = HDR_LO;
        end
      end
      HDR_LO: begin
        rx_ready_d = 1'b1;
        if (xfer) begin
          count_d = hdr_n;
          if (hdr_n == 16'd0) begin
            state_d    = DONE;
            rx_ready_d = 1'b0;
            done_d     = 1'b1;
            nrst_d     = 1'b1;
          end else if ({16'd0, hdr_n} > CAPACITY) begin
            state_d    = ERR;
            rx_ready_d = 1'b0;
            error_d    = 1'b1;
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (xfer) begin
          word_d     = {word_q[DATA_WIDTH-9:0], rx_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d    = WRITE;
            we_d       = 1'b1;
            addr_d     = word_idx_q;
            wdata_d    = word_d;
            rx_ready_d = 1'b0;
          end
        end
      end
      WRITE: begin
        if (last_word) begin
          state_d    = DONE;
          rx_ready_d = 1'b0;
          done_d     = 1'b1;
          nrst_d     = 1'b1;
        end else begin
          word_idx_d = word_idx_q + ADDR_WIDTH'(1);
          rx_ready_d = 1'b1;
          state_d    = LOAD;
        end
      end
      DONE: begin
        rx_ready_d = 1'b0;
      end
      ERR: begin
        rx_ready_d = 1'b0;
      end
      default: begin
        state_d = HDR_HI;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= HDR_HI;
      count_q    <= '0;
      word_idx_q <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
      rx_ready_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      nrst_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      word_idx_q <= word_idx_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      rx_ready_q <= rx_ready_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      nrst_q     <= nrst_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign rx_ready     = rx_ready_q;
  assign icache_we    = we_q;
  assign icache_addr  = addr_q;
  assign icache_wdata = wdata_q;
  assign core_nrst    = nrst_q;
  assign done         = done_q;
  assign error        = error_q;

endmodule

// File: tb/tb_icache_boot_loader.sv
// Directed testbench for icache_boot_loader: streams images byte by byte,
// logs every icache write and compares against hand-computed expectations.
module tb_icache_boot_loader;

  logic        clk;
  logic        rst;
  logic [7:0]  rxData;
  logic        rxValid;
  logic        rxReady;
  logic        icacheWe;
  logic [9:0]  icacheAddr;
  logic [31:0] icacheWdata;
  logic        coreNrst;
  logic        done;
  logic        error;

  int testsRun;
  int testsFailed;

  logic [9:0]  wrAddr[$];
  logic [31:0] wrData[$];
  int          wrCyc[$];
  logic [9:0]  expAddr[$];
  logic [31:0] expData[$];
  int          cyc;
  int          doneCyc;

  icache_boot_loader #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data      (rxData),
    .rx_valid     (rxValid),
    .rx_ready     (rxReady),
    .icache_we    (icacheWe),
    .icache_addr  (icacheAddr),
    .icache_wdata (icacheWdata),
    .core_nrst    (coreNrst),
    .done         (done),
    .error        (error)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Write monitor: samples on the falling edge, logs each icache write and
  // the first cycle in which done is seen high.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (icacheWe) begin
      wrAddr.push_back(icacheAddr);
      wrData.push_back(icacheWdata);
      wrCyc.push_back(cyc);
    end
    if (done && doneCyc < 0) doneCyc = cyc;
  end

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun = testsRun + 1;
    if (actual !== expected) begin
      testsFailed = testsFailed + 1;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Present one byte after an optional idle gap and wait for it to be accepted.
  // Called and returns on a falling edge.
  task automatic applyStimulus(input logic [7:0] b, input int gap);
    int waitCnt;
    rxValid = 1'b0;
    repeat (gap) @(negedge clk);
    rxData  = b;
    rxValid = 1'b1;
    waitCnt = 0;
    while (!rxReady && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!rxReady) checkOutput("rx_timeout", 32'd0, 32'd1);
    @(negedge clk);
    rxValid = 1'b0;
  endtask

  // Hold reset for two cycles, clear logs, optionally check reset values.
  task automatic resetDut(input bit checkVals);
    @(negedge clk);
    rst     = 1'b1;
    rxValid = 1'b0;
    repeat (2) @(negedge clk);
    wrAddr.delete();
    wrData.delete();
    wrCyc.delete();
    expAddr.delete();
    expData.delete();
    doneCyc = -1;
    if (checkVals) begin
      checkOutput("rst_rx_ready", 32'(rxReady), 32'd0);
      checkOutput("rst_we", 32'(icacheWe), 32'd0);
      checkOutput("rst_addr", 32'(icacheAddr), 32'd0);
      checkOutput("rst_wdata", icacheWdata, 32'd0);
      checkOutput("rst_core_nrst", 32'(coreNrst), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_error", 32'(error), 32'd0);
    end
    rst = 1'b0;
  endtask

  // Compare the logged writes against the expected list, in order.
  task automatic verifyWrites(input string tag);
    int n;
    checkOutput({tag, "_count"}, 32'(wrAddr.size()), 32'(expAddr.size()));
    n = (wrAddr.size() < expAddr.size()) ? wrAddr.size() : expAddr.size();
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s_addr%0d", tag, i), 32'(wrAddr[i]), 32'(expAddr[i]));
      checkOutput($sformatf("%s_data%0d", tag, i), wrData[i], expData[i]);
    end
  endtask

  logic [7:0] img1 [14];

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    cyc         = 0;
    doneCyc     = -1;
    rst         = 1'b1;
    rxValid     = 1'b0;
    rxData      = 8'h00;
    img1 = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB,
             8'hCC, 8'hDD, 8'h01, 8'h02, 8'h03, 8'h04};

    // Test 1: three-word image, back-to-back bytes.
    resetDut(1'b1);
    for (int i = 0; i < 14; i++) applyStimulus(img1[i], 0);
    repeat (3) @(negedge clk);
    expAddr = '{10'd0, 10'd1, 10'd2};
    expData = '{32'h11223344, 32'hAABBCCDD, 32'h01020304};
    verifyWrites("t1");
    if (wrCyc.size() == 3) checkOutput("t1_done_latency", 32'(doneCyc), 32'(wrCyc[2] + 1));
    checkOutput("t1_done", 32'(done), 32'd1);
    checkOutput("t1_core_nrst", 32'(coreNrst), 32'd1);
    checkOutput("t1_error", 32'(error), 32'd0);

    // Test 2: empty image finishes right after the header.
    resetDut(1'b0);
    applyStimulus(8'h00, 0);
    applyStimulus(8'h00, 0);
    checkOutput("t2_done", 32'(done), 32'd1);
    checkOutput("t2_core_nrst", 32'(coreNrst), 32'd1);
    repeat (3) @(negedge clk);
    checkOutput("t2_writes", 32'(wrAddr.size()), 32'd0);

    // Test 3: count 1025 exceeds a 1024-word cache.
    resetDut(1'b0);
    applyStimulus(8'h04, 0);
    applyStimulus(8'h01, 0);
    checkOutput("t3_error", 32'(error), 32'd1);
    checkOutput("t3_rx_ready", 32'(rxReady), 32'd0);
    rxData  = 8'h11;
    rxValid = 1'b1;
    repeat (6) @(negedge clk);
    rxValid = 1'b0;
    checkOutput("t3_rx_ready_hold", 32'(rxReady), 32'd0);
    checkOutput("t3_core_nrst", 32'(coreNrst), 32'd0);
    checkOutput("t3_done", 32'(done), 32'd0);
    checkOutput("t3_writes", 32'(wrAddr.size()), 32'd0);

    // Test 4: same image as test 1 with random idle gaps.
    resetDut(1'b0);
    for (int i = 0; i < 14; i++) applyStimulus(img1[i], int'($urandom_range(0, 5)));
    repeat (3) @(negedge clk);
    expAddr = '{10'd0, 10'd1, 10'd2};
    expData = '{32'h11223344, 32'hAABBCCDD, 32'h01020304};
    verifyWrites("t4");
    checkOutput("t4_done", 32'(done), 32'd1);

    // Test 5: reset mid-image, then a fresh one-word image.
    resetDut(1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(img1[i], 0);
    resetDut(1'b1);
    applyStimulus(8'h00, 0);
    applyStimulus(8'h01, 0);
    applyStimulus(8'hDE, 0);
    applyStimulus(8'hAD, 0);
    applyStimulus(8'hBE, 0);
    applyStimulus(8'hEF, 0);
    @(negedge clk);
    expAddr = '{10'd0};
    expData = '{32'hDEADBEEF};
    verifyWrites("t5");
    checkOutput("t5_done", 32'(done), 32'd1);

    // Test 6: bytes offered in DONE are ignored.
    rxData  = 8'h55;
    rxValid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput($sformatf("t6_rx_ready%0d", i), 32'(rxReady), 32'd0);
      checkOutput($sformatf("t6_done%0d", i), 32'(done), 32'd1);
    end
    rxValid = 1'b0;
    checkOutput("t6_writes", 32'(wrAddr.size()), 32'd1);

    // Test 7: exactly full capacity (1024 words) is accepted.
    resetDut(1'b0);
    applyStimulus(8'h04, 0);
    applyStimulus(8'h00, 0);
    for (int w = 0; w < 1024; w++) begin
      logic [31:0] wv;
      wv = {16'hC0DE, 6'd0, 10'(w)};
      applyStimulus(wv[31:24], 0);
      applyStimulus(wv[23:16], 0);
      applyStimulus(wv[15:8], 0);
      applyStimulus(wv[7:0], 0);
      expAddr.push_back(10'(w));
      expData.push_back(wv);
    end
    repeat (3) @(negedge clk);
    verifyWrites("t7");
    checkOutput("t7_done", 32'(done), 32'd1);
    checkOutput("t7_core_nrst", 32'(coreNrst), 32'd1);
    checkOutput("t7_error", 32'(error), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
